// File: rtl/fifo_rd_packer.sv
// Read-side packer for the 16-bit async FIFO: gathers PACK_N words into one wide beat and
// emits burst-aligned beats; a flush pads the open beat and burst with zeros.
module fifo_rd_packer #(
  parameter int DATA_W    = 16,
  parameter int PACK_N    = 4,
  parameter int BURST_LEN = 8
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  output logic                     fifo_rd_en,
  input  logic [DATA_W-1:0]        fifo_rd_data,
  input  logic                     fifo_rd_empty,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [PACK_N*DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int CW = $clog2(PACK_N);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_N - 1);
  localparam logic [CW:0]   PACK_M1   = (CW+1)'(PACK_N - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {RUN, DRAIN, PAD, DONE} state_t;

  state_t                          r_state;
  logic [CW-1:0]                   r_cnt;
  logic                            r_pend;
  logic [BW-1:0]                   r_bcnt;
  logic [PACK_N-1:0][DATA_W-1:0]   r_lanes;
  logic [PACK_N-1:0][DATA_W-1:0]   r_outData;
  logic                            r_outValid;
  logic                            r_outLast;

  state_t                          w_stateNext;
  logic [PACK_N-1:0][DATA_W-1:0]   w_lanes;
  logic [CW:0]                     w_slots;
  logic                            w_full;
  logic                            w_xfer;
  logic                            w_padLoad;
  logic                            w_load;
  logic                            w_rdEn;
  logic [BW-1:0]                   w_bcntNext;

  assign fifo_rd_en = w_rdEn;
  assign out_data   = r_outData;
  assign out_valid  = r_outValid;
  assign out_last   = r_outLast;
  assign flush_done = (r_state == DONE);

  assign w_full     = r_pend && (r_cnt == LAST_LANE);
  assign w_xfer     = r_outValid && out_ready;
  assign w_padLoad  = (r_state == PAD) && (!r_outValid || (w_xfer && !r_outLast));
  assign w_load     = w_full || w_padLoad;
  assign w_bcntNext = !w_xfer ? r_bcnt : ((r_bcnt == LAST_BEAT) ? '0 : r_bcnt + 1'b1);

  // Lanes already occupied once the in-flight word lands; a word landing in the last lane
  // empties the lanes, so it counts as zero occupancy. A pop that would complete a beat
  // needs the output register free now, since no other beat can load before it lands.
  always_comb begin
    w_slots = w_full ? '0 : ({1'b0, r_cnt} + {{CW{1'b0}}, r_pend});
    w_rdEn  = !rd_rst && (r_state == RUN) && !fifo_rd_empty &&
              ((w_slots < PACK_M1) || !r_outValid);
  end

  always_comb begin
    w_lanes = r_lanes;
    if (r_pend) begin
      w_lanes[r_cnt] = fifo_rd_data;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      RUN: begin
        if (flush) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_pend && !r_outValid) begin
          w_stateNext = ((r_cnt != '0) || (r_bcnt != '0)) ? PAD : DONE;
        end
      end
      PAD: begin
        if (w_xfer && r_outLast) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = RUN;
      end
      default: begin
        w_stateNext = RUN;
      end
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state <= RUN;
      r_pend  <= 1'b0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pend  <= w_rdEn;
      r_bcnt  <= (r_state == DONE) ? '0 : w_bcntNext;
    end
  end

  // Lanes are cleared whenever a beat loads, so padded beats carry zeros above cnt.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_cnt      <= '0;
      r_lanes    <= '0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else if (w_load) begin
      r_cnt      <= '0;
      r_lanes    <= '0;
      r_outData  <= w_lanes;
      r_outValid <= 1'b1;
      r_outLast  <= (w_bcntNext == LAST_BEAT);
    end else begin
      if (r_pend) begin
        r_cnt   <= r_cnt + 1'b1;
        r_lanes <= w_lanes;
      end
      if (w_xfer) begin
        r_outValid <= 1'b0;
      end
    end
  end

endmodule
